// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered one-hot select generator.
//   DECODE mode: out = 1 << sel, one cycle after sel is sampled.
//   SCAN mode:   a walking one that advances on step and wraps at NUM_OUT-1,
//                pulsing wrap for the cycle the index returns to 0.
// Optional feature: define ONEHOT_SEQ_DECODER_ERR_EN to get a sticky err flag
// that records any out-of-range sel seen in DECODE; otherwise err is tied low.
module onehot_seq_decoder #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               step,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t state;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

    // One-hot pattern for an index; indices past the last output give all zeros.
    function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [NUM_OUT-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            r[k] = (int'(i) == k);
        end
        return r;
    endfunction

    // True when the index addresses an existing output.
    function automatic logic in_range(input logic [SEL_W-1:0] i);
        return (int'(i) < NUM_OUT);
    endfunction

    // State machine with all outputs registered; reset, then en, take priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            wrap      <= 1'b0;
`ifdef ONEHOT_SEQ_DECODER_ERR_EN
            err       <= 1'b0;
`endif
        end else if (!en) begin
            // err is deliberately left alone: only reset clears it.
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            // Decode path: any scan position is dropped on entry.
            state <= DEC;
            wrap  <= 1'b0;
            if (in_range(sel)) begin
                out       <= onehot(sel);
                out_valid <= 1'b1;
                idx       <= sel;
            end else begin
                out       <= '0;
                out_valid <= 1'b0;
                idx       <= '0;
`ifdef ONEHOT_SEQ_DECODER_ERR_EN
                err       <= 1'b1;
`endif
            end
        end else if (state != SCAN) begin
            // Entering SCAN always restarts at index 0, step is ignored here.
            state     <= SCAN;
            out       <= onehot('0);
            out_valid <= 1'b1;
            idx       <= '0;
            wrap      <= 1'b0;
        end else if (step) begin
            out_valid <= 1'b1;
            if (idx == LAST_IDX) begin
                idx  <= '0;
                out  <= onehot('0);
                wrap <= 1'b1;
            end else begin
                idx  <= idx + SEL_W'(1);
                out  <= onehot(idx + SEL_W'(1));
                wrap <= 1'b0;
            end
        end else begin
            // Scan holds position while step is low.
            wrap <= 1'b0;
        end
    end

`ifndef ONEHOT_SEQ_DECODER_ERR_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed bench for onehot_seq_decoder: one default instance (NUM_OUT=8) and
// one NUM_OUT=6 instance share the same stimulus. err expectations follow the
// ONEHOT_SEQ_DECODER_ERR_EN macro.
module tb_onehot_seq_decoder;

`ifdef ONEHOT_SEQ_DECODER_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, mode, step;
    logic [2:0] sel;

    logic [7:0] out8;
    logic       vld8, wrap8, err8;
    logic [2:0] idx8;
    logic [5:0] out6;
    logic       vld6, wrap6, err6;
    logic [2:0] idx6;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dec8_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [5:0] dec6_exp [8] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h00};
    logic [2:0] scan6_idx [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic [5:0] scan6_out [7] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01, 6'h02};

    always #5 clk = ~clk;

    onehot_seq_decoder #(.SEL_W(3), .NUM_OUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .sel(sel),
        .out(out8), .out_valid(vld8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    onehot_seq_decoder #(.SEL_W(3), .NUM_OUT(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .sel(sel),
        .out(out6), .out_valid(vld6), .idx(idx6), .wrap(wrap6), .err(err6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] o, input logic v,
                        input logic [2:0] i, input logic w);
        chk({tag, ".out8"},  32'(out8),  32'(o));
        chk({tag, ".vld8"},  32'(vld8),  32'(v));
        chk({tag, ".idx8"},  32'(idx8),  32'(i));
        chk({tag, ".wrap8"}, 32'(wrap8), 32'(w));
        chk({tag, ".err8"},  32'(err8),  32'(0));
    endtask

    task automatic chk6(input string tag, input logic [5:0] o, input logic v,
                        input logic [2:0] i, input logic w, input logic e);
        chk({tag, ".out6"},  32'(out6),  32'(o));
        chk({tag, ".vld6"},  32'(vld6),  32'(v));
        chk({tag, ".idx6"},  32'(idx6),  32'(i));
        chk({tag, ".wrap6"}, 32'(wrap6), 32'(w));
        chk({tag, ".err6"},  32'(err6),  32'(e));
    endtask

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; step = 1'b1; sel = 3'd3;
        #1;
        tick();
        chk8("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        chk6("reset", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);

        // Decode sweep: sel 0..7, latency one cycle.
        rst_n = 1'b1; mode = 1'b0; step = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            chk8($sformatf("dec%0d", s), dec8_exp[s], 1'b1, 3'(s), 1'b0);
            chk6($sformatf("dec%0d", s), dec6_exp[s], (s < 6), (s < 6) ? 3'(s) : 3'd0,
                 1'b0, (s >= 6) ? ERR_ON : 1'b0);
        end

        // en low: IDLE, sticky err survives.
        en = 1'b0;
        tick();
        chk8("idle", 8'h00, 1'b0, 3'd0, 1'b0);
        chk6("idle", 6'h00, 1'b0, 3'd0, 1'b0, ERR_ON);

        // Scan entry then seven steps.
        en = 1'b1; mode = 1'b1; step = 1'b1;
        tick();
        chk8("scan_in", 8'h01, 1'b1, 3'd0, 1'b0);
        chk6("scan_in", 6'h01, 1'b1, 3'd0, 1'b0, ERR_ON);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk8($sformatf("scan%0d", i), dec8_exp[i + 1], 1'b1, 3'(i + 1), 1'b0);
            chk6($sformatf("scan%0d", i), scan6_out[i], 1'b1, scan6_idx[i], (i == 5), ERR_ON);
        end

        // step low holds position.
        step = 1'b0;
        tick();
        chk8("hold", 8'h80, 1'b1, 3'd7, 1'b0);
        chk6("hold", 6'h02, 1'b1, 3'd1, 1'b0, ERR_ON);

        // Last step on the 8-way wraps it too.
        step = 1'b1;
        tick();
        chk8("wrap8", 8'h01, 1'b1, 3'd0, 1'b1);
        chk6("wrap8", 6'h04, 1'b1, 3'd2, 1'b0, ERR_ON);

        // Reset mid-scan at idx 3.
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; step = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk8("at3", 8'h08, 1'b1, 3'd3, 1'b0);
        rst_n = 1'b0;
        tick();
        chk8("rst_mid", 8'h00, 1'b0, 3'd0, 1'b0);
        chk6("rst_mid", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk8("rst_rel", 8'h01, 1'b1, 3'd0, 1'b0);
        chk6("rst_rel", 6'h01, 1'b1, 3'd0, 1'b0, 1'b0);

        // Scan at idx 2, then switch to decode of sel=5 in the same cycle.
        tick();
        tick();
        chk8("at2", 8'h04, 1'b1, 3'd2, 1'b0);
        mode = 1'b0; sel = 3'd5;
        tick();
        chk8("scan2dec", 8'h20, 1'b1, 3'd5, 1'b0);
        chk6("scan2dec", 6'h20, 1'b1, 3'd5, 1'b0, 1'b0);

        // DEC back to SCAN restarts at 0 despite step.
        mode = 1'b1;
        tick();
        chk8("dec2scan", 8'h01, 1'b1, 3'd0, 1'b0);
        tick();
        chk8("scan_a", 8'h02, 1'b1, 3'd1, 1'b0);

        // en low during scan overrides step and sel.
        en = 1'b0; sel = 3'd4;
        tick();
        chk8("en_off", 8'h00, 1'b0, 3'd0, 1'b0);
        chk6("en_off", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);

        // Out-of-range decode on the 6-way, sticky through en=0, cleared by reset.
        en = 1'b1; mode = 1'b0; sel = 3'd7;
        tick();
        chk8("oor", 8'h80, 1'b1, 3'd7, 1'b0);
        chk6("oor", 6'h00, 1'b0, 3'd0, 1'b0, ERR_ON);
        en = 1'b0;
        tick();
        chk6("oor_idle", 6'h00, 1'b0, 3'd0, 1'b0, ERR_ON);
        rst_n = 1'b0;
        tick();
        chk6("oor_rst", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
